// File: rtl/bit_index_encoder.sv
// bit_index_encoder: accepts a 32-bit vector and serially emits the index of
// every set bit, lowest first, one index per dout handshake.
module bit_index_encoder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             dout_valid,
    output logic [IDX_W-1:0] dout,
    output logic             dout_last,
    input  logic             dout_ready,
    output logic             zero_seen
);

    // Index width must exactly cover the vector width.
    if (IDX_W != $clog2(WIDTH)) begin : g_bad_param
        $error("bit_index_encoder: IDX_W must equal log2(WIDTH)");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic               zero_seen_q, zero_seen_d;

    logic [IDX_W-1:0]   idx_c;
    logic               one_left_c;

    // Priority encode: lowest set bit of the remaining mask wins.
    always_comb begin
        idx_c = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                idx_c = IDX_W'(i);
            end
        end
    end

    // Exactly one bit left means the current index is the final one.
    always_comb begin
        one_left_c = (mask_q != '0) && ((mask_q & (mask_q - WIDTH'(1))) == '0);
    end

    // Next-state, mask update and zero-vector pulse.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        zero_seen_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (din_valid) begin
                    if (din != '0) begin
                        mask_d  = din;
                        state_d = SCAN;
                    end else begin
                        zero_seen_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (dout_ready) begin
                    mask_d = mask_q & ~(WIDTH'(1) << idx_c);
                    if (one_left_c) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, mask and pulse registers; reset drops any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            zero_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            zero_seen_q <= zero_seen_d;
        end
    end

    // Outputs decode from registered state only.
    always_comb begin
        din_ready  = (state_q == IDLE);
        dout_valid = (state_q == SCAN);
        dout       = (state_q == SCAN) ? idx_c : '0;
        dout_last  = (state_q == SCAN) && one_left_c;
        zero_seen  = zero_seen_q;
    end

endmodule

// File: tb/tb_bit_index_encoder.sv
// Bench for bit_index_encoder: expected indices are queued when a vector is
// sent and popped by a monitor on every output transfer.
module tb_bit_index_encoder;

    logic        clk;
    logic        rst;
    logic        din_valid;
    logic [31:0] din;
    logic        din_ready;
    logic        dout_valid;
    logic [4:0]  dout;
    logic        dout_last;
    logic        dout_ready;
    logic        zero_seen;

    int          n_vec;
    int          n_err;
    logic [5:0]  sb[$];      // {last, index}
    logic [31:0] acc;
    int          beats;

    bit_index_encoder #(.WIDTH(32), .IDX_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_last  (dout_last),
        .dout_ready (dout_ready),
        .zero_seen  (zero_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every transfer must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            logic [5:0] exp_b;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat: got idx=%0d last=%0b, expected no output", dout, dout_last);
            end else begin
                exp_b = sb.pop_front();
                if ({dout_last, dout} !== exp_b) begin
                    n_err++;
                    $display("FAIL beat: got idx=%0d last=%0b, expected idx=%0d last=%0b",
                             dout, dout_last, exp_b[4:0], exp_b[5]);
                end
            end
            acc = acc | (32'd1 << dout);
            beats++;
        end
    end

    // Present one vector for one accepted cycle and queue its expected indices.
    task automatic send_vec(input logic [31:0] v);
        int hi;
        hi = -1;
        for (int i = 0; i < 32; i++) if (v[i]) hi = i;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) sb.push_back({(i == hi), 5'(i)});
        end
        @(posedge clk); #1;
        din_valid = 1'b1;
        din       = v;
        @(posedge clk); #1;
        din_valid = 1'b0;
        din       = 32'h0;
    endtask

    // Bounded wait for the block to drain back to idle.
    task automatic wait_idle(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk); #2;
            if (din_ready && sb.size() == 0) done = 1'b1;
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_drain: din_ready=%0b pending=%0d, expected idle with 0 pending",
                     name, din_ready, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_vec++;
        if ({din_ready, dout_valid, dout, dout_last, zero_seen} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%0b vld=%0b dout=%0d last=%0b zero=%0b, expected 1 0 0 0 0",
                     din_ready, dout_valid, dout, dout_last, zero_seen);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        dout_ready = 1'b1;
        send_vec(32'h0000_0001);
        n_vec++;
        if ({dout_valid, dout, dout_last, din_ready} !== {1'b1, 5'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL single_beat: got vld=%0b dout=%0d last=%0b rdy=%0b, expected 1 0 1 0",
                     dout_valid, dout, dout_last, din_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({dout_valid, din_ready, dout} !== {1'b0, 1'b1, 5'd0}) begin
            n_err++;
            $display("FAIL single_done: got vld=%0b rdy=%0b dout=%0d, expected 0 1 0",
                     dout_valid, din_ready, dout);
        end
    endtask

    task automatic test_multi();
        dout_ready = 1'b1;
        send_vec(32'h8000_0011);
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (din_ready !== 1'b0) begin
                n_err++;
                $display("FAIL multi_busy: cycle %0d got din_ready=%0b, expected 0", c, din_ready);
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if ({din_ready, dout_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL multi_done: got rdy=%0b vld=%0b, expected 1 0", din_ready, dout_valid);
        end
    endtask

    task automatic test_backpressure();
        dout_ready = 1'b0;
        send_vec(32'h0000_0006);
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if ({dout_valid, dout, dout_last} !== {1'b1, 5'd1, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold: cycle %0d got vld=%0b dout=%0d last=%0b, expected 1 1 0",
                         c, dout_valid, dout, dout_last);
            end
            @(posedge clk); #1;
        end
        dout_ready = 1'b1;
        wait_idle(10, "bp");
    endtask

    task automatic test_zero();
        dout_ready = 1'b1;
        send_vec(32'h0000_0000);
        n_vec++;
        if ({zero_seen, dout_valid, din_ready} !== 3'b101) begin
            n_err++;
            $display("FAIL zero_pulse: got zero=%0b vld=%0b rdy=%0b, expected 1 0 1",
                     zero_seen, dout_valid, din_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({zero_seen, dout_valid, din_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL zero_after: got zero=%0b vld=%0b rdy=%0b, expected 0 0 1",
                     zero_seen, dout_valid, din_ready);
        end
    endtask

    task automatic test_all_ones();
        dout_ready = 1'b1;
        acc   = 32'h0;
        beats = 0;
        send_vec(32'hFFFF_FFFF);
        wait_idle(40, "ones");
        n_vec++;
        if (acc !== 32'hFFFF_FFFF || beats != 32) begin
            n_err++;
            $display("FAIL ones_roundtrip: got acc=%h beats=%0d, expected ffffffff 32", acc, beats);
        end
    endtask

    task automatic test_reset_mid_scan();
        dout_ready = 1'b1;
        send_vec(32'h0000_F000);
        @(posedge clk); #1;
        n_vec++;
        if ({dout_valid, dout} !== {1'b1, 5'd13}) begin
            n_err++;
            $display("FAIL mid_second: got vld=%0b dout=%0d, expected 1 13", dout_valid, dout);
        end
        rst = 1'b1;
        sb.delete();
        #1;
        n_vec++;
        if ({dout_valid, din_ready, dout} !== {1'b0, 1'b1, 5'd0}) begin
            n_err++;
            $display("FAIL mid_async: got vld=%0b rdy=%0b dout=%0d, expected 0 1 0",
                     dout_valid, din_ready, dout);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({dout_valid, din_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL mid_release: got vld=%0b rdy=%0b, expected 0 1", dout_valid, din_ready);
        end
        send_vec(32'h0000_0002);
        n_vec++;
        if ({dout_valid, dout, dout_last} !== {1'b1, 5'd1, 1'b1}) begin
            n_err++;
            $display("FAIL mid_new: got vld=%0b dout=%0d last=%0b, expected 1 1 1",
                     dout_valid, dout, dout_last);
        end
        wait_idle(10, "mid");
    endtask

    task automatic test_back_to_back();
        dout_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            send_vec($urandom());
            wait_idle(40, "b2b");
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        acc        = 32'h0;
        beats      = 0;
        din_valid  = 1'b0;
        din        = 32'h0;
        dout_ready = 1'b1;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_zero();
        test_all_ones();
        test_reset_mid_scan();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
